vid_frame_sequencer: RTL and testbench

Frame-timing controller that sequences the camera-side pixel interface (`FV`, `LV`, `D_IN`) feeding the video-in to AXI4-Stream converter. It generates one frame or continuous frames with programmable back/front porches and a deterministic test pattern. It can also insert blank line time when the downstream stream path requests a stall. It sits in the `pclk` domain and replaces the bench-only frame generator as a synthesizable source for bring-up and self-test.

---
 rtl/vid_frame_sequencer_pkg.sv | 37 +++
 rtl/vid_frame_sequencer_if.sv | 34 +++
 rtl/vid_frame_sequencer_line_timer.sv | 51 +++++
 rtl/vid_frame_sequencer.sv | 173 +++++++++++++++++
 tb/tb_vid_frame_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/vid_frame_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// vid_frame_sequencer_pkg
// Shared definitions for the frame-timing sequencer:
//   - default frame geometry (active size and porches)
//   - vfs_state_t, the sequencer FSM state encoding
//   - test-pattern format: D_IN = {line_idx[7:0], pix_idx[7:0]}
// -----------------------------------------------------------------------------
package vid_frame_sequencer_pkg;

  localparam int unsigned VFS_H_ACTIVE  = 640;
  localparam int unsigned VFS_V_ACTIVE  = 480;
  localparam int unsigned VFS_H_B_PORCH = 120;
  localparam int unsigned VFS_H_F_PORCH = 200;
  localparam int unsigned VFS_V_B_PORCH = 120;
  localparam int unsigned VFS_V_F_PORCH = 100;

  // Counter and pattern field widths.
  localparam int unsigned VFS_CNT_W      = 16;
  localparam int unsigned VFS_PAT_LINE_W = 8;
  localparam int unsigned VFS_PAT_PIX_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VBP   = 3'd1,
    ST_ACT   = 3'd2,
    ST_STALL = 3'd3,
    ST_VFP   = 3'd4
  } vfs_state_t;

  function automatic logic [VFS_CNT_W-1:0] vfs_pattern(
    input logic [VFS_PAT_LINE_W-1:0] line_idx,
    input logic [VFS_PAT_PIX_W-1:0]  pix_idx
  );
    return {line_idx, pix_idx};
  endfunction

endpackage

// File: rtl/vid_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// vid_frame_sequencer_if
// Control inputs and camera-side pixel outputs of the frame sequencer.
//   master : host / bench side, drives start, cont, stop, stall_req
//   slave  : sequencer side, drives FV, LV, D_IN, line_no, frame_cnt,
//            frame_done, busy
// Handshake: there is no valid/ready pair here. start is a level sampled on
// every rising pclk edge while idle; stop is a level sampled on every edge
// while busy; stall_req is a level sampled only on active-line ends and while
// stalled. All slave outputs are registered.
// -----------------------------------------------------------------------------
interface vid_frame_sequencer_if;
  logic        start;
  logic        cont;
  logic        stop;
  logic        stall_req;
  logic        FV;
  logic        LV;
  logic [15:0] D_IN;
  logic [15:0] line_no;
  logic [15:0] frame_cnt;
  logic        frame_done;
  logic        busy;

  modport master (
    output start, cont, stop, stall_req,
    input  FV, LV, D_IN, line_no, frame_cnt, frame_done, busy
  );

  modport slave (
    input  start, cont, stop, stall_req,
    output FV, LV, D_IN, line_no, frame_cnt, frame_done, busy
  );
endinterface

// File: rtl/vid_frame_sequencer_line_timer.sv
// -----------------------------------------------------------------------------
// vfs_line_timer
// Horizontal counter for the frame sequencer. h_cnt runs 0..L-1 with
// L = H_B_PORCH + H_ACTIVE + H_F_PORCH and is parked at 0 when not running.
// Because the sequencer registers its outputs, this block also exposes a
// look-ahead view of the next cycle's h_cnt (LV window, pixel index, end).
// Ports:
//   pclk, reset      : clock, async active-high reset
//   i_run            : 1 = count this cycle, 0 = next h_cnt is 0
//   o_line_end       : current h_cnt == L-1
//   o_line_end_nxt   : next h_cnt == L-1
//   o_lv_nxt         : next h_cnt lies in the active window
//   o_pix_nxt        : low byte of (next h_cnt - H_B_PORCH)
// -----------------------------------------------------------------------------
module vfs_line_timer #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_B_PORCH = 120,
  parameter int unsigned H_F_PORCH = 200
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       i_run,
  output logic       o_line_end,
  output logic       o_line_end_nxt,
  output logic       o_lv_nxt,
  output logic [7:0] o_pix_nxt
);

  localparam logic [15:0] H_LAST  = 16'(H_B_PORCH + H_ACTIVE + H_F_PORCH - 1);
  localparam logic [16:0] H_BP17  = 17'(H_B_PORCH);
  localparam logic [15:0] H_ACT16 = 16'(H_ACTIVE);

  logic [15:0] r_h_cnt;
  logic [15:0] w_h_nxt;
  logic [16:0] w_off;

  assign o_line_end     = (r_h_cnt == H_LAST);
  assign w_h_nxt        = (!i_run || o_line_end) ? 16'd0 : r_h_cnt + 16'd1;
  assign o_line_end_nxt = (w_h_nxt == H_LAST);

  // 17-bit subtract: bit 16 is the borrow, i.e. "still inside the back porch".
  assign w_off     = {1'b0, w_h_nxt} - H_BP17;
  assign o_lv_nxt  = !w_off[16] && (w_off[15:0] < H_ACT16);
  assign o_pix_nxt = w_off[7:0];

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) r_h_cnt <= '0;
    else       r_h_cnt <= w_h_nxt;
  end

endmodule

// File: rtl/vid_frame_sequencer.sv
// -----------------------------------------------------------------------------
// vid_frame_sequencer
// Synthesizable camera-side frame generator (FV / LV / D_IN) with programmable
// porches, single or continuous frames, and a {line, pixel} test pattern.
// Optional feature macro: VFS_STALL_EN. When defined, stall_req sampled on the
// last cycle of any active line but the final one inserts blank STALL cycles
// (FV=1, LV=0) until stall_req drops. When undefined, stall_req is ignored and
// frame length is exact.
// Ports:
//   pclk, reset  : pixel clock, async active-high reset
//   bus (slave)  : start/cont/stop/stall_req in; FV, LV, D_IN, line_no,
//                  frame_cnt, frame_done, busy out (all registered)
//   o_dbg_state  : current FSM state
// -----------------------------------------------------------------------------
module vid_frame_sequencer
  import vid_frame_sequencer_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = VFS_H_ACTIVE,
  parameter int unsigned V_ACTIVE  = VFS_V_ACTIVE,
  parameter int unsigned H_B_PORCH = VFS_H_B_PORCH,
  parameter int unsigned H_F_PORCH = VFS_H_F_PORCH,
  parameter int unsigned V_B_PORCH = VFS_V_B_PORCH,
  parameter int unsigned V_F_PORCH = VFS_V_F_PORCH
) (
  input  logic                    pclk,
  input  logic                    reset,
  vid_frame_sequencer_if.slave    bus,
  output vfs_state_t              o_dbg_state
);

  localparam logic [15:0] V_BP_LAST  = 16'(V_B_PORCH - 1);
  localparam logic [15:0] V_ACT_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] V_FP_LAST  = 16'(V_F_PORCH - 1);
  localparam bit          HAS_VBP    = (V_B_PORCH != 0);
  localparam bit          HAS_VFP    = (V_F_PORCH != 0);
  localparam vfs_state_t  FIRST_ST   = HAS_VBP ? ST_VBP : ST_ACT;

  vfs_state_t  r_state, w_state_nxt;
  logic [15:0] r_v_cnt, w_v_nxt;
  logic        r_cont, r_stop_pend;
  logic        r_fv, r_lv, r_frame_done, r_busy;
  logic [15:0] r_d_in, r_line_no, r_frame_cnt;

  logic        w_run, w_line_end, w_line_end_nxt, w_lv_nxt, w_frame_end, w_last_nxt;
  logic [7:0]  w_pix_nxt;

  assign w_run = (r_state != ST_IDLE) && (r_state != ST_STALL);

  vfs_line_timer #(
    .H_ACTIVE  (H_ACTIVE),
    .H_B_PORCH (H_B_PORCH),
    .H_F_PORCH (H_F_PORCH)
  ) u_line_timer (
    .pclk           (pclk),
    .reset          (reset),
    .i_run          (w_run),
    .o_line_end     (w_line_end),
    .o_line_end_nxt (w_line_end_nxt),
    .o_lv_nxt       (w_lv_nxt),
    .o_pix_nxt      (w_pix_nxt)
  );

  // Next-state decode; v_cnt counts lines within the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_v_nxt     = r_v_cnt;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = FIRST_ST;
          w_v_nxt     = '0;
        end
      end
      ST_VBP: begin
        if (w_line_end) begin
          if (r_v_cnt == V_BP_LAST) begin
            w_state_nxt = ST_ACT;
            w_v_nxt     = '0;
          end else begin
            w_v_nxt = r_v_cnt + 16'd1;
          end
        end
      end
      ST_ACT: begin
        if (w_line_end) begin
          if (r_v_cnt == V_ACT_LAST) begin
            w_v_nxt = '0;
            if (HAS_VFP) w_state_nxt = ST_VFP;
            else         w_frame_end = 1'b1;
          end else begin
            // v_cnt already points at the next line while stalled.
            w_v_nxt = r_v_cnt + 16'd1;
`ifdef VFS_STALL_EN
            if (bus.stall_req) w_state_nxt = ST_STALL;
`endif
          end
        end
      end
`ifdef VFS_STALL_EN
      ST_STALL: begin
        if (!bus.stall_req) w_state_nxt = ST_ACT;
      end
`endif
      ST_VFP: begin
        if (w_line_end) begin
          if (r_v_cnt == V_FP_LAST) w_frame_end = 1'b1;
          else                      w_v_nxt     = r_v_cnt + 16'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_frame_end) begin
      w_v_nxt     = '0;
      w_state_nxt = (r_stop_pend || !r_cont) ? ST_IDLE : FIRST_ST;
    end
  end

  // The next cycle is the last frame cycle: last line of the frame, h = L-1.
  assign w_last_nxt = w_line_end_nxt &&
                      (((w_state_nxt == ST_VFP) && (w_v_nxt == V_FP_LAST)) ||
                       (!HAS_VFP && (w_state_nxt == ST_ACT) && (w_v_nxt == V_ACT_LAST)));

  // FSM state plus outputs registered from the next-cycle view.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_v_cnt      <= '0;
      r_cont       <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_fv         <= 1'b0;
      r_lv         <= 1'b0;
      r_d_in       <= '0;
      r_line_no    <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_v_cnt <= w_v_nxt;

      if (r_state == ST_IDLE) begin
        r_stop_pend <= 1'b0;
        // start together with stop runs exactly one frame.
        if (bus.start) r_cont <= bus.cont & ~bus.stop;
      end else if (w_frame_end && (w_state_nxt == ST_IDLE)) begin
        r_stop_pend <= 1'b0;
      end else if (bus.stop) begin
        r_stop_pend <= 1'b1;
      end

      r_busy       <= (w_state_nxt != ST_IDLE);
      r_fv         <= (w_state_nxt == ST_ACT) || (w_state_nxt == ST_STALL);
      r_lv         <= (w_state_nxt == ST_ACT) && w_lv_nxt;
      r_d_in       <= ((w_state_nxt == ST_ACT) && w_lv_nxt) ?
                      vfs_pattern(w_v_nxt[7:0], w_pix_nxt) : '0;
      r_frame_done <= w_last_nxt;
      if (w_state_nxt == ST_ACT) r_line_no   <= w_v_nxt;
      if (w_frame_end)           r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign bus.FV         = r_fv;
  assign bus.LV         = r_lv;
  assign bus.D_IN       = r_d_in;
  assign bus.line_no    = r_line_no;
  assign bus.frame_cnt  = r_frame_cnt;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = r_busy;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_vid_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vid_frame_sequencer
// Directed bench for vid_frame_sequencer with the small geometry
// H_ACTIVE=4, V_ACTIVE=3, H/V porches 2/2/1/1 (L=8, 40-cycle frame), plus a
// second instance with a 1-cycle frame used to walk frame_cnt through its wrap.
// Cycle n is the period after rising edge E(n-1); inputs "at cycle n" are
// driven on the falling edge inside cycle n and sampled at E(n); outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_vid_frame_sequencer;
  import vid_frame_sequencer_pkg::*;

  localparam int H_ACT = 4;
  localparam int V_ACT = 3;
  localparam int H_BP  = 2;
  localparam int H_FP  = 2;
  localparam int V_BP  = 1;
  localparam int V_FP  = 1;
  localparam int LINE  = H_BP + H_ACT + H_FP;        // 8
  localparam int FRAME = (V_BP + V_ACT + V_FP) * LINE; // 40
`ifdef VFS_STALL_EN
  localparam int STALL_LEN = 4;
`else
  localparam int STALL_LEN = 0;
`endif

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic reset;
  always #5 pclk = ~pclk;

  vid_frame_sequencer_if vif ();
  vid_frame_sequencer_if vif_t ();
  vfs_state_t dbg_state, dbg_state_t;

  vid_frame_sequencer #(
    .H_ACTIVE (H_ACT), .V_ACTIVE (V_ACT),
    .H_B_PORCH(H_BP),  .H_F_PORCH(H_FP),
    .V_B_PORCH(V_BP),  .V_F_PORCH(V_FP)
  ) u_dut (
    .pclk        (pclk),
    .reset       (reset),
    .bus         (vif),
    .o_dbg_state (dbg_state)
  );

  // One pixel per line, one line per frame, no porches: one frame per cycle.
  vid_frame_sequencer #(
    .H_ACTIVE (1), .V_ACTIVE (1),
    .H_B_PORCH(0), .H_F_PORCH(0),
    .V_B_PORCH(0), .V_F_PORCH(0)
  ) u_tiny (
    .pclk        (pclk),
    .reset       (reset),
    .bus         (vif_t),
    .o_dbg_state (dbg_state_t)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_frames = 0;
  logic [15:0] exp_q[$];   // expected frame_done cycle numbers

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, act, exp);
    end
  endtask

  // Expected pixel-side outputs on frame cycle n (1-based). A stall of s
  // cycles follows active line 0, whose last cycle is cycle 16.
  function automatic void model(input int n, input int s,
                                output logic fv, output logic lv,
                                output logic [15:0] d, output int line,
                                output bit in_stall);
    int m, ln, off;
    in_stall = (s > 0) && (n >= 17) && (n <= 16 + s);
    fv = 1'b0; lv = 1'b0; d = 16'h0; line = 0;
    if (in_stall) begin
      fv = 1'b1;
    end else begin
      m   = ((s > 0) && (n > 16 + s)) ? n - s : n;
      ln  = (m - 1) / LINE;
      off = (m - 1) % LINE;
      fv  = (ln >= V_BP) && (ln < V_BP + V_ACT);
      line = ln - V_BP;
      lv  = fv && (off >= H_BP) && (off < H_BP + H_ACT);
      d   = lv ? {8'(line), 8'(off - H_BP)} : 16'h0;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic run_seq(input string name, input bit cont_v, input bit stop_v,
                         input int frames, input int stall_len, input int stop_cyc,
                         input int stall_on, input int stall_off, input int abort_cyc);
    int flen, total, n, line;
    logic fv, lv;
    logic [15:0] d;
    bit in_stall, aborted;
    flen = FRAME + stall_len;
    total = flen * frames;
    aborted = 1'b0;
    @(negedge pclk);                  // cycle 0
    vif.start = 1'b1; vif.cont = cont_v; vif.stop = stop_v;
    for (int f = 0; f < frames; f++) exp_q.push_back(16'((f + 1) * flen));
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge pclk);
      if (c == 1) begin vif.start = 1'b0; vif.cont = 1'b0; vif.stop = 1'b0; end
      n = ((c - 1) % flen) + 1;
      if (c <= total) begin
        model(n, stall_len, fv, lv, d, line, in_stall);
        check_eq($sformatf("%s busy c%0d", name, c), 16'(vif.busy), 16'h1);
        check_eq($sformatf("%s FV c%0d", name, c), 16'(vif.FV), 16'(fv));
        check_eq($sformatf("%s LV c%0d", name, c), 16'(vif.LV), 16'(lv));
        check_eq($sformatf("%s D_IN c%0d", name, c), vif.D_IN, d);
        check_eq($sformatf("%s frame_cnt c%0d", name, c), vif.frame_cnt,
                 16'(exp_frames + (c - 1) / flen));
        if (in_stall) begin
          check_eq($sformatf("%s state c%0d", name, c), 16'(dbg_state), 16'(ST_STALL));
          check_eq($sformatf("%s line_no c%0d", name, c), vif.line_no, 16'h0);
        end else if (fv) begin
          check_eq($sformatf("%s line_no c%0d", name, c), vif.line_no, 16'(line));
        end
      end else begin
        check_eq($sformatf("%s busy c%0d", name, c), 16'(vif.busy), 16'h0);
        check_eq($sformatf("%s FV c%0d", name, c), 16'(vif.FV), 16'h0);
        check_eq($sformatf("%s frame_cnt c%0d", name, c), vif.frame_cnt,
                 16'(exp_frames + frames));
      end
      if (vif.frame_done) begin
        if (exp_q.size() == 0)
          check_eq($sformatf("%s frame_done extra", name), 16'(c), 16'h0);
        else
          check_eq($sformatf("%s frame_done cycle", name), 16'(c), exp_q.pop_front());
      end
      vif.stop      = (c == stop_cyc);
      vif.stall_req = (c >= stall_on) && (c < stall_off);
      if (c == abort_cyc) begin
        reset = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    vif.stop = 1'b0; vif.stall_req = 1'b0;
    if (aborted) begin
      exp_q.delete();
    end else begin
      check_eq($sformatf("%s frame_done missing", name), 16'(exp_q.size()), 16'h0);
      exp_q.delete();
      exp_frames += frames;
    end
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, " FV"},         16'(vif.FV),         16'h0);
    check_eq({name, " LV"},         16'(vif.LV),         16'h0);
    check_eq({name, " D_IN"},       vif.D_IN,            16'h0);
    check_eq({name, " line_no"},    vif.line_no,         16'h0);
    check_eq({name, " frame_cnt"},  vif.frame_cnt,       16'h0);
    check_eq({name, " frame_done"}, 16'(vif.frame_done), 16'h0);
    check_eq({name, " busy"},       16'(vif.busy),       16'h0);
    check_eq({name, " state"},      16'(dbg_state),      16'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int waited;
    reset = 1'b1;
    vif.start = 1'b0;   vif.cont = 1'b0;   vif.stop = 1'b0;   vif.stall_req = 1'b0;
    vif_t.start = 1'b0; vif_t.cont = 1'b0; vif_t.stop = 1'b0; vif_t.stall_req = 1'b0;
    repeat (2) @(negedge pclk);
    check_all_zero("reset");
    check_eq("reset tiny busy", 16'(vif_t.busy), 16'h0);
    reset = 1'b0;
    repeat (2) @(negedge pclk);

    run_seq("single",     1'b0, 1'b0, 1, 0,         0,  0,  0,  0);
    run_seq("continuous", 1'b1, 1'b0, 2, 0,         45, 0,  0,  0);
    run_seq("stall",      1'b0, 1'b0, 1, STALL_LEN, 0,  16, 20, 0);
    run_seq("start_stop", 1'b1, 1'b1, 1, 0,         0,  0,  0,  0);

    run_seq("abort", 1'b0, 1'b0, 1, 0, 0, 0, 0, 20);
    @(negedge pclk);                  // cycle 21, reset asserted since cycle 20
    check_all_zero("midreset");
    reset = 1'b0;
    exp_frames = 0;
    repeat (2) @(negedge pclk);
    run_seq("restart", 1'b0, 1'b0, 1, 0, 0, 0, 0, 0);

    // frame_cnt wrap on the one-cycle-frame instance: cycle c shows c-1.
    @(negedge pclk);
    vif_t.start = 1'b1; vif_t.cont = 1'b1;
    @(negedge pclk);                  // cycle 1
    vif_t.start = 1'b0; vif_t.cont = 1'b0;
    check_eq("tiny busy c1",       16'(vif_t.busy),       16'h1);
    check_eq("tiny LV c1",         16'(vif_t.LV),         16'h1);
    check_eq("tiny frame_done c1", 16'(vif_t.frame_done), 16'h1);
    check_eq("tiny frame_cnt c1",  vif_t.frame_cnt,       16'h0000);
    repeat (65535) @(negedge pclk);   // cycle 65536
    check_eq("tiny frame_cnt max", vif_t.frame_cnt, 16'hFFFF);
    @(negedge pclk);                  // cycle 65537
    check_eq("tiny frame_cnt wrap",  vif_t.frame_cnt,       16'h0000);
    check_eq("tiny frame_done wrap", 16'(vif_t.frame_done), 16'h1);
    vif_t.stop = 1'b1;
    @(negedge pclk);
    vif_t.stop = 1'b0;
    waited = 0;
    while (vif_t.busy && waited < 8) begin
      @(negedge pclk);
      waited++;
    end
    check_eq("tiny stop idle", 16'(vif_t.busy), 16'h0);
    check_eq("tiny stop FV",   16'(vif_t.FV),   16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
